// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the hardwired control sequencer: state encoding, opcode
// values, dataPath strobe bundle and the Moore strobe decode.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALTED, S_FAULT
    } state_e;

    localparam int unsigned OPC_LD   = 0;
    localparam int unsigned OPC_LDI  = 1;
    localparam int unsigned OPC_ST   = 2;
    localparam int unsigned OPC_ADD  = 3;
    localparam int unsigned OPC_HALT = 31;

    typedef enum logic [2:0] {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_HALT, OP_ILL} op_e;

    localparam logic [1:0] MDR_SRC_BUS = 2'b00;
    localparam logic [1:0] MDR_SRC_MEM = 2'b01;
    localparam logic [3:0] ALU_NOP     = 4'd0;
    localparam logic [3:0] ALU_OP_ADD  = 4'd2;

    typedef struct packed {
        logic       pc_out;
        logic       inc_pc;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       zlow_in;
        logic       zlow_out;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       c_out;
        logic       read;
        logic       write;
        logic [1:0] mdr_read;
        logic       alu_add;
        logic       halted;
        logic       fault;
    } strobes_t;

    // Instructions whose address/operand comes from base register + constant.
    function automatic logic uses_ba(op_e op);
        return op inside {OP_LD, OP_LDI, OP_ST};
    endfunction

    function automatic strobes_t decode(state_e s, op_e op);
        strobes_t o;
        o = '0;
        case (s)
            S_T0: begin
                o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.zlow_in = 1'b1;
            end
            S_T1: begin
                o.zlow_out = 1'b1; o.pc_in = 1'b1; o.read = 1'b1;
                o.mdr_read = MDR_SRC_MEM; o.mdr_in = 1'b1;
            end
            S_T1W: begin
                o.read = 1'b1; o.mdr_read = MDR_SRC_MEM; o.mdr_in = 1'b1;
            end
            S_T2: begin
                o.mdr_out = 1'b1; o.ir_in = 1'b1;
            end
            S_T3: begin
                if (uses_ba(op)) begin
                    o.grb = 1'b1; o.ba_out = 1'b1; o.y_in = 1'b1;
                end else if (op == OP_ADD) begin
                    o.grb = 1'b1; o.r_out = 1'b1; o.y_in = 1'b1;
                end
            end
            S_T4: begin
                if (uses_ba(op)) begin
                    o.c_out = 1'b1; o.alu_add = 1'b1; o.zlow_in = 1'b1;
                end else if (op == OP_ADD) begin
                    o.grc = 1'b1; o.r_out = 1'b1; o.alu_add = 1'b1; o.zlow_in = 1'b1;
                end
            end
            S_T5: begin
                o.zlow_out = 1'b1;
                if (op == OP_LDI || op == OP_ADD) begin
                    o.gra = 1'b1; o.r_in = 1'b1;
                end else begin
                    o.mar_in = 1'b1;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    o.read = 1'b1; o.mdr_read = MDR_SRC_MEM; o.mdr_in = 1'b1;
                end else if (op == OP_ST) begin
                    o.gra = 1'b1; o.ba_out = 1'b1; o.mdr_read = MDR_SRC_BUS; o.mdr_in = 1'b1;
                end
            end
            S_T7: begin
                if (op == OP_LD) begin
                    o.mdr_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1;
                end else if (op == OP_ST) begin
                    o.write = 1'b1;
                end
            end
            S_HALTED: o.halted = 1'b1;
            S_FAULT:  o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; flags the cycle on which
// the WAIT_MAX-th unanswered wait cycle occurs.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A completing cycle never ticks, so completion beats timeout.
    assign expired = tick && !clear && (cnt_q == CW'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for dataPath; strobes are registered from
// the decode of the next state so they equal a Moore decode of the state.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned OPC_W    = 5,
    parameter int unsigned OPC_LSB  = 27,
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16,
    parameter logic [3:0]  ALU_ADD  = ALU_OP_ADD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_ready,
    output logic              PCout,
    output logic              IncPc,
    output logic              PCin,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Zlowin,
    output logic              Zlowout,
    output logic              GRA,
    output logic              GRB,
    output logic              GRC,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              Cout,
    output logic              read,
    output logic              write,
    output logic [1:0]        mdr_read,
    output logic [3:0]        control,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  instr_cnt
);

    function automatic op_e classify(logic [OPC_W-1:0] opc);
        if (opc == OPC_W'(OPC_LD))   return OP_LD;
        if (opc == OPC_W'(OPC_LDI))  return OP_LDI;
        if (opc == OPC_W'(OPC_ST))   return OP_ST;
        if (opc == OPC_W'(OPC_ADD))  return OP_ADD;
        if (opc == OPC_W'(OPC_HALT)) return OP_HALT;
        return OP_ILL;
    endfunction

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    strobes_t         strobes_q, strobes_d;
    op_e              op_c;
    logic             in_wait_c;
    logic             expired_c;
    logic             retire_c;
    logic             unused_ir;

    assign op_c      = classify(opcode_q);
    assign unused_ir = ^ir;

    // Cycles that stall on mem_ready.
    always_comb begin
        in_wait_c = 1'b0;
        case (state_q)
            S_T1W:   in_wait_c = 1'b1;
            S_T6:    in_wait_c = (op_c == OP_LD);
            S_T7:    in_wait_c = (op_c == OP_ST);
            default: ;
        endcase
    end

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (~in_wait_c),
        .tick    (in_wait_c & ~mem_ready),
        .expired (expired_c)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        instr_cnt_d = instr_cnt_q;
        retire_c    = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = mem_ready ? S_T2 : S_T1W;
            S_T1W: begin
                if (mem_ready)      state_d = S_T2;
                else if (expired_c) state_d = S_FAULT;
            end
            S_T2: begin
                state_d  = S_T3;
                opcode_d = ir[OPC_LSB +: OPC_W];
            end
            S_T3: begin
                case (op_c)
                    OP_HALT: state_d = S_HALTED;
                    OP_ILL:  state_d = S_FAULT;
                    default: state_d = S_T4;
                endcase
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (op_c == OP_LDI || op_c == OP_ADD) retire_c = 1'b1;
                else                                  state_d  = S_T6;
            end
            S_T6: begin
                if (op_c != OP_LD || mem_ready) state_d = S_T7;
                else if (expired_c)             state_d = S_FAULT;
            end
            S_T7: begin
                if (op_c == OP_LD || mem_ready) retire_c = 1'b1;
                else if (expired_c)             state_d  = S_FAULT;
            end
            default: ;
        endcase
        if (retire_c) begin
            state_d     = S_T0;
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
        strobes_d = decode(state_d, classify(opcode_d));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            instr_cnt_q <= '0;
            strobes_q   <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            instr_cnt_q <= instr_cnt_d;
            strobes_q   <= strobes_d;
        end
    end

    assign PCout     = strobes_q.pc_out;
    assign IncPc     = strobes_q.inc_pc;
    assign PCin      = strobes_q.pc_in;
    assign MARin     = strobes_q.mar_in;
    assign MDRin     = strobes_q.mdr_in;
    assign MDRout    = strobes_q.mdr_out;
    assign IRin      = strobes_q.ir_in;
    assign Yin       = strobes_q.y_in;
    assign Zlowin    = strobes_q.zlow_in;
    assign Zlowout   = strobes_q.zlow_out;
    assign GRA       = strobes_q.gra;
    assign GRB       = strobes_q.grb;
    assign GRC       = strobes_q.grc;
    assign Rin       = strobes_q.r_in;
    assign Rout      = strobes_q.r_out;
    assign BAout     = strobes_q.ba_out;
    assign Cout      = strobes_q.c_out;
    assign read      = strobes_q.read;
    assign write     = strobes_q.write;
    assign mdr_read  = strobes_q.mdr_read;
    assign control   = strobes_q.alu_add ? ALU_ADD : ALU_NOP;
    assign halted    = strobes_q.halted;
    assign fault     = strobes_q.fault;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: builds the expected per-cycle strobe trace of
// each instruction from its opcode and memory wait counts, then replays it.
module tb_control_sequencer;

    localparam int unsigned WAIT_MAX = 16;
    localparam int unsigned CNT_W    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic mem_ready = 1'b0;
    logic [31:0] ir = '0;

    logic o_pc_out, o_inc_pc, o_pc_in, o_mar_in, o_mdr_in, o_mdr_out, o_ir_in;
    logic o_y_in, o_zlow_in, o_zlow_out, o_gra, o_grb, o_grc, o_r_in, o_r_out;
    logic o_ba_out, o_c_out, o_read, o_write, o_halted, o_fault;
    logic [1:0] o_mdr_read;
    logic [3:0] o_control;
    logic [CNT_W-1:0] o_instr_cnt;

    always #5 clk = ~clk;

    control_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(o_pc_out), .IncPc(o_inc_pc), .PCin(o_pc_in), .MARin(o_mar_in),
        .MDRin(o_mdr_in), .MDRout(o_mdr_out), .IRin(o_ir_in), .Yin(o_y_in),
        .Zlowin(o_zlow_in), .Zlowout(o_zlow_out), .GRA(o_gra), .GRB(o_grb),
        .GRC(o_grc), .Rin(o_r_in), .Rout(o_r_out), .BAout(o_ba_out), .Cout(o_c_out),
        .read(o_read), .write(o_write), .mdr_read(o_mdr_read), .control(o_control),
        .halted(o_halted), .fault(o_fault), .instr_cnt(o_instr_cnt)
    );

    localparam logic [18:0] S_PCOUT  = 19'h40000, S_INCPC = 19'h20000, S_PCIN  = 19'h10000;
    localparam logic [18:0] S_MARIN  = 19'h08000, S_MDRIN = 19'h04000, S_MDROUT = 19'h02000;
    localparam logic [18:0] S_IRIN   = 19'h01000, S_YIN   = 19'h00800, S_ZIN   = 19'h00400;
    localparam logic [18:0] S_ZOUT   = 19'h00200, S_GRA   = 19'h00100, S_GRB   = 19'h00080;
    localparam logic [18:0] S_GRC    = 19'h00040, S_RIN   = 19'h00020, S_ROUT  = 19'h00010;
    localparam logic [18:0] S_BAOUT  = 19'h00008, S_COUT  = 19'h00004, S_READ  = 19'h00002;
    localparam logic [18:0] S_WRITE  = 19'h00001;

    typedef struct packed {
        logic [18:0]      strb;
        logic [1:0]       sel;
        logic [3:0]       ctl;
        logic             halted;
        logic             fault;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    typedef struct packed {
        obs_t        exp;
        logic        chk;
        logic        rst;
        logic        run;
        logic        mr;
        logic [31:0] ir;
    } step_t;

    step_t plan[$];
    obs_t  got[$];
    int    model_cnt = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [31:0] rw();
        return $urandom;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.strb = {o_pc_out, o_inc_pc, o_pc_in, o_mar_in, o_mdr_in, o_mdr_out, o_ir_in,
                  o_y_in, o_zlow_in, o_zlow_out, o_gra, o_grb, o_grc, o_r_in, o_r_out,
                  o_ba_out, o_c_out, o_read, o_write};
        o.sel    = o_mdr_read;
        o.ctl    = o_control;
        o.halted = o_halted;
        o.fault  = o_fault;
        o.cnt    = o_instr_cnt;
        return o;
    endfunction

    // Model: one cycle of an instruction; ret marks the retiring cycle.
    task automatic add(input logic [18:0] s, input logic [1:0] sel, input logic alu,
                       input logic mr, input logic [31:0] irv, input logic ret);
        step_t e;
        e = '0;
        e.exp.strb = s;
        e.exp.sel  = sel;
        e.exp.ctl  = alu ? 4'd2 : 4'd0;
        e.exp.cnt  = CNT_W'(model_cnt);
        e.chk = 1'b1;
        e.run = rb();
        e.mr  = mr;
        e.ir  = irv;
        plan.push_back(e);
        if (ret) model_cnt++;
    endtask

    task automatic add_reset();
        step_t e;
        e = '0;
        e.rst = 1'b1;
        e.run = rb();
        e.mr  = rb();
        e.ir  = rw();
        plan.push_back(e);
        model_cnt = 0;
    endtask

    task automatic add_idle(input logic run_v);
        step_t e;
        e = '0;
        e.chk = 1'b1;
        e.run = run_v;
        e.mr  = rb();
        e.ir  = rw();
        e.exp.cnt = CNT_W'(model_cnt);
        plan.push_back(e);
    endtask

    task automatic add_stuck(input int n, input logic h, input logic f);
        step_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.chk = 1'b1;
            e.run = 1'b1;
            e.mr  = rb();
            e.ir  = rw();
            e.exp.halted = h;
            e.exp.fault  = f;
            e.exp.cnt    = CNT_W'(model_cnt);
            plan.push_back(e);
        end
    endtask

    // Memory wait: nlow unanswered cycles then completion, unless WAIT_MAX lows come first.
    task automatic wait_phase(input logic [18:0] s, input logic [1:0] sel, input int nlow,
                              input logic ret, output bit tout);
        tout = 1'b1;
        for (int i = 0; i < int'(WAIT_MAX); i++) begin
            add(s, sel, 1'b0, i == nlow, rw(), (i == nlow) && ret);
            if (i == nlow) begin
                tout = 1'b0;
                break;
            end
        end
    endtask

    // wf: extra fetch-wait cycles; wm: unanswered memory cycles in LD-T6 / ST-T7.
    task automatic emit(input int opc, input int wf, input int wm, output bit stopped);
        logic [31:0] irv;
        bit tout;
        irv = rw();
        irv[31:27] = 5'(opc);
        stopped = 1'b0;
        add(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 2'b00, 1'b0, rb(), rw(), 1'b0);
        add(S_ZOUT | S_PCIN | S_READ | S_MDRIN, 2'b01, 1'b0, wf == 0, rw(), 1'b0);
        if (wf > 0) begin
            wait_phase(S_READ | S_MDRIN, 2'b01, wf - 1, 1'b0, tout);
            if (tout) begin add_stuck(4, 1'b0, 1'b1); stopped = 1'b1; return; end
        end
        add(S_MDROUT | S_IRIN, 2'b00, 1'b0, rb(), irv, 1'b0);
        case (opc)
            0, 1, 2: add(S_GRB | S_BAOUT | S_YIN, 2'b00, 1'b0, rb(), rw(), 1'b0);
            3:       add(S_GRB | S_ROUT | S_YIN, 2'b00, 1'b0, rb(), rw(), 1'b0);
            default: begin
                add('0, 2'b00, 1'b0, rb(), rw(), 1'b0);
                add_stuck(4, opc == 31, opc != 31);
                stopped = 1'b1;
                return;
            end
        endcase
        if (opc == 3) add(S_GRC | S_ROUT | S_ZIN, 2'b00, 1'b1, rb(), rw(), 1'b0);
        else          add(S_COUT | S_ZIN, 2'b00, 1'b1, rb(), rw(), 1'b0);
        if (opc == 1 || opc == 3) begin
            add(S_ZOUT | S_GRA | S_RIN, 2'b00, 1'b0, rb(), rw(), 1'b1);
            return;
        end
        add(S_ZOUT | S_MARIN, 2'b00, 1'b0, rb(), rw(), 1'b0);
        if (opc == 0) begin
            wait_phase(S_READ | S_MDRIN, 2'b01, wm, 1'b0, tout);
            if (tout) begin add_stuck(4, 1'b0, 1'b1); stopped = 1'b1; return; end
            add(S_MDROUT | S_GRA | S_RIN, 2'b00, 1'b0, rb(), rw(), 1'b1);
        end else begin
            add(S_GRA | S_BAOUT | S_MDRIN, 2'b00, 1'b0, rb(), rw(), 1'b0);
            wait_phase(S_WRITE, 2'b00, wm, 1'b1, tout);
            if (tout) begin add_stuck(4, 1'b0, 1'b1); stopped = 1'b1; end
        end
    endtask

    task automatic play();
        got.delete();
        foreach (plan[i]) begin
            got.push_back(sample());
            reset     = plan[i].rst;
            run       = plan[i].run;
            mem_ready = plan[i].mr;
            ir        = plan[i].ir;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        plan.delete();
        model_cnt = 0;
        for (int i = 0; i < 4; i++) add_idle(1'b0);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_ldi();
        bit st;
        int start;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        start = plan.size();
        emit(1, 0, 0, st);
        add(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 2'b00, 1'b0, rb(), rw(), 1'b0);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL ldi cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
        n_checks++;
        if (got[start + 6].cnt !== CNT_W'(1) || got[start + 5].strb !== (S_ZOUT | S_GRA | S_RIN)) begin
            n_errors++;
            $display("FAIL ldi_latency: cnt %0d strobes %h required cnt 1 strobes %h",
                     got[start + 6].cnt, got[start + 5].strb, S_ZOUT | S_GRA | S_RIN);
        end
    endtask

    task automatic test_st_wait();
        bit st;
        int wcnt;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        emit(2, $urandom_range(0, 2), 3, st);
        emit(1, 0, 0, st);
        play();
        wcnt = 0;
        foreach (plan[i]) begin
            if (plan[i].chk) begin
                n_checks++;
                if (got[i] !== plan[i].exp) begin
                    n_errors++;
                    $display("FAIL st_wait cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
                end
            end
            if (got[i].strb[0] === 1'b1) wcnt++;
        end
        n_checks++;
        if (wcnt !== 4) begin
            n_errors++;
            $display("FAIL st_write_len: got %0d cycles required 4", wcnt);
        end
    endtask

    task automatic test_ld_timeout();
        bit st;
        int rcnt;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        emit(0, 0, WAIT_MAX, st);
        add_reset();
        add_idle(1'b0);
        play();
        rcnt = 0;
        foreach (plan[i]) begin
            if (plan[i].chk) begin
                n_checks++;
                if (got[i] !== plan[i].exp) begin
                    n_errors++;
                    $display("FAIL ld_timeout cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
                end
            end
            if (got[i].strb[1] === 1'b1) rcnt++;
        end
        n_checks++;
        if (rcnt !== int'(WAIT_MAX) + 1) begin
            n_errors++;
            $display("FAIL ld_read_len: got %0d cycles required %0d", rcnt, WAIT_MAX + 1);
        end
    endtask

    task automatic test_boundary();
        bit st;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        emit(0, WAIT_MAX, WAIT_MAX - 1, st);
        emit(2, 0, WAIT_MAX - 1, st);
        emit(1, WAIT_MAX + 1, 0, st);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL boundary cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        bit st;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        emit(1, 0, 0, st);
        emit(9, 1, 0, st);
        add_reset();
        add_idle(1'b1);
        emit(3, 0, 0, st);
        emit(int'($urandom_range(4, 30)), 0, 0, st);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL illegal cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_halt();
        bit st;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        emit(1, 0, 0, st);
        emit(31, 0, 0, st);
        add_reset();
        add_idle(1'b0);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL halt cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
        n_checks++;
        if (got[got.size() - 2].halted !== 1'b1 || got[got.size() - 1].halted !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_clear: halted before/after reset %b/%b required 1/0",
                     got[got.size() - 2].halted, got[got.size() - 1].halted);
        end
    endtask

    task automatic test_reset_mid();
        bit st;
        int idx;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        emit(1, 0, 0, st);
        idx = plan.size() + 6 + 1;
        emit(0, 1, 5, st);
        while (plan.size() > idx + 1) void'(plan.pop_back());
        plan[idx].rst = 1'b1;
        model_cnt = 0;
        add_idle(1'b0);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_wrap();
        bit st;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        for (int k = 0; k < 5; k++) emit(1, $urandom_range(0, 1), 0, st);
        add(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 2'b00, 1'b0, rb(), rw(), 1'b0);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL wrap cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
        n_checks++;
        if (got[got.size() - 1].cnt !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL wrap_count: got %0d required 1", got[got.size() - 1].cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit st;
        plan.delete();
        add_reset();
        add_idle(1'b1);
        for (int k = 0; k < 30; k++) begin
            emit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), st);
        end
        emit(1, 0, 0, st);
        play();
        foreach (plan[i]) if (plan[i].chk) begin
            n_checks++;
            if (got[i] !== plan[i].exp) begin
                n_errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, got[i], plan[i].exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_st_wait();
        test_ld_timeout();
        test_boundary();
        test_illegal();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
